sdram_frame_reader: RTL and testbench

SDRAM_FRAME_READER -- requirements
Module: sdram_frame_reader

---
 rtl/sdram_frame_reader_if.sv | 28 ++
 rtl/sdram_frame_reader.sv | 136 +++++++++++++
 tb/tb_sdram_frame_reader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_frame_reader_if.sv
// Bus bundle for the frame reader: Avalon-MM read master toward SDRAM plus
// the valid/ready pixel stream toward the consumer.
interface sdram_frame_reader_if;
    logic        SD_read;
    logic [25:0] SD_address;
    logic        waitrequest;
    logic [31:0] SD_rdata;
    logic        SD_readdatavalid;
    logic [7:0]  read_r;
    logic [7:0]  read_g;
    logic [7:0]  read_b;
    logic        pix_valid;
    logic        pix_ready;
    logic [16:0] Pixel_Number;
    logic        pix_last;

    modport master (
        output SD_read, SD_address, read_r, read_g, read_b,
               pix_valid, Pixel_Number, pix_last,
        input  waitrequest, SD_rdata, SD_readdatavalid, pix_ready
    );

    modport slave (
        input  SD_read, SD_address, read_r, read_g, read_b,
               pix_valid, Pixel_Number, pix_last,
        output waitrequest, SD_rdata, SD_readdatavalid, pix_ready
    );
endinterface

// File: rtl/sdram_frame_reader.sv
// Streams one frame of 32-bit pixels out of SDRAM through a credit-limited
// FIFO and presents them as a valid/ready RGB pixel stream.
module sdram_frame_reader #(
    parameter int          FRAME_PIXELS = 76800,
    parameter logic [25:0] BASE_ADDR    = 26'h0,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    sdram_frame_reader_if.master        bus,
    output logic                        busy,
    output logic                        done
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam int          CW         = AW + 1;
    localparam logic [16:0] LAST_PIX   = 17'(FRAME_PIXELS - 1);
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic [25:0]   req_addr;
    logic [16:0]   req_count;
    logic [16:0]   pix_num;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [23:0]   head;
    logic          fifo_valid;
    logic          credit_ok;
    logic          accept;
    logic          push;
    logic          pop;
    logic          last_req;
    logic          last_pix;

    // Requests in flight count against FIFO space so returning data always fits.
    assign credit_ok  = ({1'b0, fifo_count} + {1'b0, outstanding}) < CREDIT_MAX;
    assign accept     = bus.SD_read & ~bus.waitrequest;
    assign push       = bus.SD_readdatavalid & (state != IDLE);
    assign fifo_valid = (fifo_count != '0);
    assign pop        = fifo_valid & bus.pix_ready;
    assign last_req   = (req_count == LAST_PIX);
    assign last_pix   = (pix_num == LAST_PIX);
    assign head       = mem[rd_ptr];

    assign bus.SD_read      = (state == ISSUE) & credit_ok;
    assign bus.SD_address   = req_addr;
    assign bus.pix_valid    = fifo_valid;
    assign bus.read_b       = fifo_valid ? head[23:16] : 8'h00;
    assign bus.read_g       = fifo_valid ? head[15:8]  : 8'h00;
    assign bus.read_r       = fifo_valid ? head[7:0]   : 8'h00;
    assign bus.Pixel_Number = pix_num;
    assign bus.pix_last     = fifo_valid & last_pix;
    assign busy             = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_addr  <= BASE_ADDR;
            req_count <= '0;
            pix_num   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pop) begin
                pix_num <= last_pix ? 17'd0 : pix_num + 17'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ISSUE;
                        req_addr  <= BASE_ADDR;
                        req_count <= '0;
                        pix_num   <= '0;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        req_addr  <= req_addr + 26'd4;
                        req_count <= req_count + 17'd1;
                        if (last_req) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && last_pix) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            case ({accept, push})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Storage needs no reset; the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.SD_rdata[23:0];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && fifo_count == FULL_CNT));

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Scoreboard bench: a negedge harness models the SDRAM slave and the pixel
// consumer; every accepted read queues its expected pixel for comparison.
module tb_sdram_frame_reader;
    localparam int          FRAME_PIXELS = 20;
    localparam logic [25:0] BASE_ADDR    = 26'h0;
    localparam int          FIFO_DEPTH   = 16;
    localparam int          LAST         = FRAME_PIXELS - 1;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    sdram_frame_reader_if bus();

    sdram_frame_reader #(
        .FRAME_PIXELS (FRAME_PIXELS),
        .BASE_ADDR    (BASE_ADDR),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] resp_q[$];
    logic [40:0] expect_q[$];
    logic [40:0] e;
    logic [31:0] data;
    int  req_k = 0, accepts = 0, xfers = 0, done_count = 0;
    int  stall_at = -1, stall_left = 0, stall_seen = 0;
    int  cycle = 0, last_xfer_cycle = 0, exp_k = 0;
    bit  first_frame = 1'b1, track_gap = 1'b0, junk_rdv = 1'b0;
    bit  done_due = 1'b0, last_now = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave, consumer monitor and done tracking, all settled 1 time unit after negedge.
    always begin
        @(negedge clk);
        #1;
        cycle++;
        if (rst) begin
            resp_q.delete();
            expect_q.delete();
            bus.SD_readdatavalid = 1'b0;
            bus.waitrequest      = 1'b0;
            done_due             = 1'b0;
        end else begin
            if (start && !busy) begin
                req_k   = 0;
                accepts = 0;
                xfers   = 0;
            end
            if (resp_q.size() > 0) begin
                bus.SD_readdatavalid = 1'b1;
                bus.SD_rdata         = resp_q.pop_front();
            end else if (junk_rdv) begin
                bus.SD_readdatavalid = 1'b1;
                bus.SD_rdata         = 32'hDEADBEEF;
            end else begin
                bus.SD_readdatavalid = 1'b0;
                bus.SD_rdata         = 32'h0;
            end
            if (busy && stall_left > 0 && req_k == stall_at) begin
                bus.waitrequest = 1'b1;
                stall_left--;
                stall_seen++;
                checkOutput("stall_read", bus.SD_read, 1);
                checkOutput("stall_addr", bus.SD_address, 32'(BASE_ADDR + 26'(4 * stall_at)));
            end else begin
                bus.waitrequest = 1'b0;
            end
            if (bus.SD_read && !bus.waitrequest) begin
                checkOutput("addr", bus.SD_address, 32'(BASE_ADDR + 26'(4 * req_k)));
                data = (first_frame && req_k == 0) ? 32'hFF112233 : $urandom;
                resp_q.push_back(data);
                expect_q.push_back({req_k[16:0], data[23:16], data[15:8], data[7:0]});
                req_k++;
                accepts++;
            end
            last_now = 1'b0;
            if (bus.pix_valid && bus.pix_ready) begin
                if (expect_q.size() == 0) begin
                    checkOutput("unexpected_pixel", 1, 0);
                end else begin
                    e     = expect_q.pop_front();
                    exp_k = int'(e[40:24]);
                    checkOutput("pixel_number", bus.Pixel_Number, 32'(e[40:24]));
                    checkOutput("read_r", bus.read_r, 32'(e[7:0]));
                    checkOutput("read_g", bus.read_g, 32'(e[15:8]));
                    checkOutput("read_b", bus.read_b, 32'(e[23:16]));
                    checkOutput("pix_last", bus.pix_last, 32'(exp_k == LAST));
                    if (first_frame && exp_k == 0)
                        checkOutput("rgb_ff112233", {8'h00, bus.read_b, bus.read_g, bus.read_r}, 32'h00112233);
                    if (track_gap && exp_k > 0)
                        checkOutput("gap", cycle - last_xfer_cycle, 1);
                    last_xfer_cycle = cycle;
                    xfers++;
                    last_now = (exp_k == LAST);
                end
            end
            if (done || done_due) checkOutput("done", done, 32'(done_due));
            if (done) done_count++;
            done_due = last_now;
        end
    end

    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2 checkOutput("busy_after_start", busy, 1);
    endtask

    task automatic waitDone(input int budget);
        int d0;
        int n;
        d0 = done_count;
        n  = 0;
        while (done_count == d0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (done_count == d0) checkOutput("done_timeout", 0, 1);
    endtask

    initial begin
        int n;
        int dc;
        rst = 1'b1;
        start = 1'b0;
        bus.pix_ready = 1'b1;
        bus.waitrequest = 1'b0;
        bus.SD_readdatavalid = 1'b0;
        bus.SD_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #2;
        checkOutput("rst_sd_read", bus.SD_read, 0);
        checkOutput("rst_pix_valid", bus.pix_valid, 0);
        checkOutput("rst_pix_last", bus.pix_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_addr", bus.SD_address, 32'(BASE_ADDR));
        checkOutput("rst_pixnum", bus.Pixel_Number, 0);
        checkOutput("rst_rgb", {8'h00, bus.read_r, bus.read_g, bus.read_b}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Read data arriving while idle must be dropped.
        @(negedge clk);
        junk_rdv = 1'b1;
        repeat (2) @(negedge clk);
        junk_rdv = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        checkOutput("idle_rdv_discard", bus.pix_valid, 0);
        checkOutput("idle_busy", busy, 0);

        track_gap = 1'b1;
        applyStimulus();
        waitDone(200);
        checkOutput("f1_xfers", xfers, FRAME_PIXELS);
        checkOutput("f1_accepts", accepts, FRAME_PIXELS);
        track_gap = 1'b0;
        first_frame = 1'b0;

        stall_at = 3;
        stall_left = 5;
        stall_seen = 0;
        applyStimulus();
        waitDone(200);
        checkOutput("f2_stall_cycles", stall_seen, 5);
        checkOutput("f2_xfers", xfers, FRAME_PIXELS);
        checkOutput("f2_accepts", accepts, FRAME_PIXELS);
        stall_at = -1;

        // Consumer stalled: credits must cap requests at the FIFO depth.
        bus.pix_ready = 1'b0;
        applyStimulus();
        repeat (40) @(negedge clk);
        #2;
        checkOutput("f3_accepts_capped", accepts, FIFO_DEPTH);
        checkOutput("f3_sd_read_off", bus.SD_read, 0);
        checkOutput("f3_pix_valid", bus.pix_valid, 1);
        checkOutput("f3_hold_pixnum", bus.Pixel_Number, 0);
        if (expect_q.size() > 0)
            checkOutput("f3_hold_rgb", {8'h00, bus.read_b, bus.read_g, bus.read_r}, 32'(expect_q[0][23:0]));
        else
            checkOutput("f3_expect_empty", 0, 1);
        @(negedge clk);
        bus.pix_ready = 1'b1;
        waitDone(200);
        checkOutput("f3_xfers", xfers, FRAME_PIXELS);

        applyStimulus();
        n = 0;
        while (xfers < 3 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput("f4_three_pixels", xfers, 3);
        dc = done_count;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_pix_valid", bus.pix_valid, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_sd_read", bus.SD_read, 0);
        repeat (5) @(negedge clk);
        #2 checkOutput("abort_no_done", done_count, dc);
        applyStimulus();
        waitDone(200);
        checkOutput("f4_restart_xfers", xfers, FRAME_PIXELS);

        dc = done_count;
        applyStimulus();
        repeat (5) @(negedge clk);
        applyStimulus();
        waitDone(200);
        repeat (10) @(negedge clk);
        #2;
        checkOutput("f5_xfers", xfers, FRAME_PIXELS);
        checkOutput("f5_accepts", accepts, FRAME_PIXELS);
        checkOutput("f5_done_once", done_count, dc + 1);
        checkOutput("f5_idle_busy", busy, 0);
        checkOutput("f5_idle_sd_read", bus.SD_read, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
